// File: rtl/program_sequencer.sv
// Batch controller for the 9-bit-ISA core: launches the selected stored programs
// in ascending order, times each run, and aborts the batch on a run timeout.
module program_sequencer #(
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned TIMEOUT      = 4000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [2:0]           run_mask,
  input  logic                 cpu_done,
  output logic                 cpu_start,
  output logic [1:0]           cpu_program_num,
  output logic                 busy,
  output logic                 all_done,
  output logic                 timeout_err,
  output logic [1:0]           err_prog,
  input  logic [1:0]           rd_sel,
  output logic [CNT_WIDTH-1:0] rd_count
);

  localparam int unsigned SW = (START_CYCLES > 1) ? $clog2(START_CYCLES + 1) : 1;
  localparam logic [SW-1:0]        START_V   = SW'(START_CYCLES);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_V = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SELECT, LAUNCH, RUN} state_t;

  state_t               state;
  logic [2:0]           pending;
  logic [CNT_WIDTH-1:0] count [3];
  logic [CNT_WIDTH-1:0] run_cnt;
  logic [SW-1:0]        start_cnt;
  logic [1:0]           next_prog;
  logic [2:0]           next_bit;
  logic [1:0]           wr_idx;
  logic [1:0]           rd_idx;

  // Lowest pending program first, so programs always run in ascending order.
  always_comb begin
    next_prog = 2'd0;
    next_bit  = 3'b000;
    if (pending[0]) begin
      next_prog = 2'd1;
      next_bit  = 3'b001;
    end else if (pending[1]) begin
      next_prog = 2'd2;
      next_bit  = 3'b010;
    end else if (pending[2]) begin
      next_prog = 2'd3;
      next_bit  = 3'b100;
    end
  end

  assign wr_idx   = cpu_program_num - 2'd1;
  assign rd_idx   = rd_sel - 2'd1;
  assign rd_count = (rd_sel == 2'd0) ? '0 : count[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pending         <= '0;
      run_cnt         <= '0;
      start_cnt       <= '0;
      cpu_start       <= 1'b0;
      cpu_program_num <= '0;
      busy            <= 1'b0;
      all_done        <= 1'b0;
      timeout_err     <= 1'b0;
      err_prog        <= '0;
      for (int unsigned i = 0; i < 3; i++) count[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_start       <= 1'b0;
          cpu_program_num <= '0;
          busy            <= 1'b0;
          if (go) begin
            pending     <= run_mask;
            all_done    <= (run_mask == 3'b000);
            timeout_err <= 1'b0;
            err_prog    <= '0;
            for (int unsigned i = 0; i < 3; i++) count[i] <= '0;
            if (run_mask != 3'b000) begin
              state <= SELECT;
              busy  <= 1'b1;
            end
          end
        end
        SELECT: begin
          if (pending != 3'b000) begin
            pending         <= pending & ~next_bit;
            cpu_program_num <= next_prog;
            run_cnt         <= '0;
            start_cnt       <= SW'(1);
            cpu_start       <= 1'b1;
            state           <= LAUNCH;
          end else begin
            state           <= IDLE;
            busy            <= 1'b0;
            all_done        <= 1'b1;
            cpu_program_num <= '0;
          end
        end
        LAUNCH: begin
          // start_cnt counts cycles cpu_start has already been high.
          if (start_cnt == START_V) begin
            cpu_start <= 1'b0;
            state     <= RUN;
          end else begin
            start_cnt <= start_cnt + SW'(1);
          end
        end
        RUN: begin
          if (cpu_done) begin
            count[wr_idx] <= run_cnt;
            state         <= SELECT;
          end else if (run_cnt == TIMEOUT_V) begin
            count[wr_idx]   <= TIMEOUT_V;
            timeout_err     <= 1'b1;
            err_prog        <= cpu_program_num;
            pending         <= '0;
            busy            <= 1'b0;
            cpu_program_num <= '0;
            state           <= IDLE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: stimulus queues expected launches and
// batch-end snapshots; a monitor pops and compares when the DUT presents them.
module tb_program_sequencer;
  localparam int ST = 2;
  localparam int CW = 16;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic [2:0]    run_mask = 3'b000;
  logic          cpu_done = 1'b0;
  logic          cpu_start;
  logic [1:0]    cpu_program_num;
  logic          busy;
  logic          all_done;
  logic          timeout_err;
  logic [1:0]    err_prog;
  logic [1:0]    rd_sel = 2'd0;
  logic [CW-1:0] rd_count;

  program_sequencer #(.START_CYCLES(ST), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .go(go), .run_mask(run_mask), .cpu_done(cpu_done),
    .cpu_start(cpu_start), .cpu_program_num(cpu_program_num), .busy(busy),
    .all_done(all_done), .timeout_err(timeout_err), .err_prog(err_prog),
    .rd_sel(rd_sel), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ad;
    int te;
    int ep;
    int c1;
    int c2;
    int c3;
  } end_t;

  end_t exp_end[$];
  int   exp_launch[$];
  int   delays[$];    // per launch: k cycles, -1 never done, -2 done held high through LAUNCH
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic end_t mk(input int ad, input int te, input int ep,
                              input int c1, input int c2, input int c3);
    end_t e;
    e.ad = ad; e.te = te; e.ep = ep; e.c1 = c1; e.c2 = c2; e.c3 = c3;
    return e;
  endfunction

  // Core model: answers each launch with done after the queued delay.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (cpu_start) begin
        d = (delays.size() > 0) ? delays.pop_front() : -1;
        if (d == -2) begin
          cpu_done = 1'b1;
          d = 0;
        end
        do @(negedge clk); while (cpu_start);
        if (d >= 0) begin
          repeat (d) @(negedge clk);
          cpu_done = 1'b1;
          @(negedge clk);
        end
        cpu_done = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    logic ps, pb, pad, pte;
    int   width, got;
    end_t e;
    int   ec [4];
    ps = 1'b0; pb = 1'b0; pad = 1'b0; pte = 1'b0; width = 0;
    forever begin
      @(negedge clk);
      if (cpu_start && !ps) begin
        width = 0;
        if (exp_launch.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_launch: got prog %0d expected none", cpu_program_num);
        end else begin
          got = exp_launch.pop_front();
          chk("launch_prog", int'(cpu_program_num), got);
          chk("launch_busy", int'(busy), 1);
        end
      end
      if (cpu_start) width++;
      if (!cpu_start && ps) chk("start_width", width, ST);
      if ((pb && !busy) || (all_done && !pad) || (timeout_err && !pte)) begin
        if (exp_end.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_end: got all_done=%0d timeout_err=%0d expected none",
                   all_done, timeout_err);
        end else begin
          e = exp_end.pop_front();
          chk("end_all_done", int'(all_done), e.ad);
          chk("end_timeout_err", int'(timeout_err), e.te);
          chk("end_err_prog", int'(err_prog), e.ep);
          chk("end_busy", int'(busy), 0);
          chk("end_prog_num", int'(cpu_program_num), 0);
          chk("end_start", int'(cpu_start), 0);
          ec[0] = 0; ec[1] = e.c1; ec[2] = e.c2; ec[3] = e.c3;
          for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            #1;
            chk($sformatf("rd_count[%0d]", s), int'(rd_count), ec[s]);
          end
          rd_sel = 2'd0;
        end
      end
      ps = cpu_start; pb = busy; pad = all_done; pte = timeout_err;
    end
  end

  task automatic start_batch(input logic [2:0] mask);
    @(negedge clk);
    run_mask = mask;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((busy || !(all_done || timeout_err)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(n < budget), 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    // 1: reset held, then go together with reset
    repeat (2) @(negedge clk);
    go = 1'b1;
    run_mask = 3'b001;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_start", int'(cpu_start), 0);
      chk("rst_prog", int'(cpu_program_num), 0);
      chk("rst_flags", int'({all_done, timeout_err, err_prog}), 0);
    end
    go = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 2: single program, done after 10 RUN cycles
    exp_launch.push_back(1);
    delays.push_back(10);
    exp_end.push_back(mk(1, 0, 0, 10, 0, 0));
    start_batch(3'b001);
    wait_idle("t2_done", 100);

    // 3: programs 1 and 3, go pulsed mid-batch
    exp_launch.push_back(1);
    exp_launch.push_back(3);
    delays.push_back(5);
    delays.push_back(7);
    exp_end.push_back(mk(1, 0, 0, 5, 0, 7));
    start_batch(3'b101);
    repeat (6) @(negedge clk);
    run_mask = 3'b010;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_idle("t3_done", 100);

    // 4: timeout on program 1, program 2 dropped
    exp_launch.push_back(1);
    delays.push_back(-1);
    exp_end.push_back(mk(0, 1, 1, TO, 0, 0));
    start_batch(3'b011);
    wait_idle("t4_done", 100);

    // 5: empty mask completes one cycle after go
    exp_end.push_back(mk(1, 0, 0, 0, 0, 0));
    start_batch(3'b000);
    chk("t5_all_done", int'(all_done), 1);
    chk("t5_busy", int'(busy), 0);
    repeat (6) @(negedge clk);

    // 5b: done high during LAUNCH ignored, done on first RUN cycle -> 0
    exp_launch.push_back(2);
    delays.push_back(-2);
    exp_end.push_back(mk(1, 0, 0, 0, 0, 0));
    start_batch(3'b010);
    wait_idle("t5b_done", 100);

    // 6: reset mid-RUN of program 2, then clean restart
    exp_launch.push_back(1);
    exp_launch.push_back(2);
    delays.push_back(3);
    delays.push_back(15);
    exp_end.push_back(mk(0, 0, 0, 0, 0, 0));
    start_batch(3'b011);
    n = 0;
    while (!(cpu_program_num == 2'd2 && busy && !cpu_start) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_run2", int'(n < 60), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_start", int'(cpu_start), 0);
    chk("t6_prog", int'(cpu_program_num), 0);
    chk("t6_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    exp_launch.push_back(2);
    exp_launch.push_back(3);
    delays.push_back(2);
    delays.push_back(4);
    exp_end.push_back(mk(1, 0, 0, 0, 2, 4));
    start_batch(3'b110);
    wait_idle("t6_restart_done", 100);

    chk("launch_queue_empty", exp_launch.size(), 0);
    chk("end_queue_empty", exp_end.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
